// File: rtl/cr16_control_if.sv
// Handshake and control bundle between the CR16 control unit (master) and its
// memories/datapath (slave).
interface cr16_control_if;
    logic        I_ENABLE;
    logic        O_FETCH_REQ;
    logic [15:0] O_PC;
    logic [15:0] I_INSTR;
    logic        I_INSTR_VALID;
    logic        O_MEM_READ;
    logic [15:0] O_MEM_ADDR;
    logic [15:0] I_MEM_DATA;
    logic        I_MEM_VALID;
    logic [15:0] I_B;
    logic [3:0]  O_REG_A_SELECT;
    logic [3:0]  O_REG_B_SELECT;
    logic [3:0]  O_OPCODE;
    logic [15:0] O_IMMEDIATE;
    logic        O_IMMEDIATE_SELECT;
    logic [15:0] O_REGFILE_DATA;
    logic        O_REGFILE_DATA_SELECT;
    logic [15:0] O_REG_WRITE_ENABLE;
    logic        O_ILLEGAL;

    modport master (
        input  I_ENABLE, I_INSTR, I_INSTR_VALID, I_MEM_DATA, I_MEM_VALID, I_B,
        output O_FETCH_REQ, O_PC, O_MEM_READ, O_MEM_ADDR, O_REG_A_SELECT, O_REG_B_SELECT,
               O_OPCODE, O_IMMEDIATE, O_IMMEDIATE_SELECT, O_REGFILE_DATA,
               O_REGFILE_DATA_SELECT, O_REG_WRITE_ENABLE, O_ILLEGAL
    );

    modport slave (
        output I_ENABLE, I_INSTR, I_INSTR_VALID, I_MEM_DATA, I_MEM_VALID, I_B,
        input  O_FETCH_REQ, O_PC, O_MEM_READ, O_MEM_ADDR, O_REG_A_SELECT, O_REG_B_SELECT,
               O_OPCODE, O_IMMEDIATE, O_IMMEDIATE_SELECT, O_REGFILE_DATA,
               O_REGFILE_DATA_SELECT, O_REG_WRITE_ENABLE, O_ILLEGAL
    );
endinterface

// File: rtl/cr16_control.sv
// CR16 multi-cycle control: FETCH -> DECODE -> EXECUTE (-> MEM_WAIT for LOAD), 3 cycles
// for register ops, 4+ for LOAD; each stalled handshake cycle or I_ENABLE-low cycle holds state.
module cr16_control #(
    parameter logic [15:0] PC_RESET = 16'h0000
) (
    input  logic           I_CLK,
    input  logic           I_RESET,
    cr16_control_if.master bus
);
    typedef enum logic [1:0] {FETCH, DECODE, EXECUTE, MEM_WAIT} state_t;

    state_t      state, state_nxt;
    logic [15:0] pc, ir;
    logic        ld_ir, ld_dec, en;

    logic [3:0]  d_ra, d_rb, d_opc;
    logic [15:0] d_imm, d_rf_data;
    logic        d_imm_sel, d_rf_sel, d_mov, d_load, d_illegal, d_write;

    logic [3:0]  c_opc;
    logic [15:0] c_imm, c_rf_data;
    logic        c_imm_sel, c_rf_sel, c_mov, c_load, c_illegal, c_write;
    logic [4:0]  alu_r, alu_i;

    // {valid, ALU opcode} for an R-type opext / immediate-form op code
    function automatic logic [4:0] alu_code(input logic [3:0] code);
        case (code)
            4'b0001: return {1'b1, 4'd5};
            4'b0010: return {1'b1, 4'd6};
            4'b0011: return {1'b1, 4'd7};
            4'b0101: return {1'b1, 4'd0};
            4'b0110: return {1'b1, 4'd1};
            4'b1001: return {1'b1, 4'd3};
            4'b1110: return {1'b1, 4'd2};
            4'b1111: return {1'b1, 4'd4};
            default: return 5'b0;
        endcase
    endfunction

    always_comb begin
        c_opc     = 4'd0;
        c_imm     = 16'h0000;
        c_rf_data = 16'h0000;
        c_imm_sel = 1'b0;
        c_rf_sel  = 1'b0;
        c_mov     = 1'b0;
        c_load    = 1'b0;
        c_illegal = 1'b0;
        c_write   = 1'b0;
        alu_r     = alu_code(ir[7:4]);
        alu_i     = alu_code(ir[15:12]);
        case (ir[15:12])
            4'b0000: begin
                if (alu_r[4]) begin
                    c_write = 1'b1;
                    c_opc   = alu_r[3:0];
                end else if (ir[7:4] == 4'b1101) begin
                    c_write  = 1'b1;
                    c_rf_sel = 1'b1;
                    c_mov    = 1'b1;
                end else begin
                    c_illegal = 1'b1;
                end
            end
            4'b1101: begin
                c_write   = 1'b1;
                c_rf_sel  = 1'b1;
                c_rf_data = {8'h00, ir[7:0]};
            end
            4'b1111: begin
                c_write   = 1'b1;
                c_rf_sel  = 1'b1;
                c_rf_data = {ir[7:0], 8'h00};
            end
            4'b0100: begin
                if (ir[7:4] == 4'b0000) c_load = 1'b1;
                else                    c_illegal = 1'b1;
            end
            default: begin
                if (alu_i[4]) begin
                    c_write   = 1'b1;
                    c_opc     = alu_i[3:0];
                    c_imm_sel = 1'b1;
                    // logical immediates zero-extend, arithmetic ones sign-extend
                    if (ir[15:12] == 4'b0001 || ir[15:12] == 4'b0010 || ir[15:12] == 4'b0011)
                        c_imm = {8'h00, ir[7:0]};
                    else
                        c_imm = {{8{ir[7]}}, ir[7:0]};
                end else begin
                    c_illegal = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge I_CLK) begin
        if (I_RESET) state <= FETCH;
        else         state <= state_nxt;
    end

    always_comb begin
        en                     = bus.I_ENABLE && !I_RESET;
        state_nxt              = state;
        ld_ir                  = 1'b0;
        ld_dec                 = 1'b0;
        bus.O_FETCH_REQ        = 1'b0;
        bus.O_MEM_READ         = 1'b0;
        bus.O_ILLEGAL          = 1'b0;
        bus.O_REG_WRITE_ENABLE = 16'h0000;
        case (state)
            FETCH: begin
                bus.O_FETCH_REQ = en;
                if (en && bus.I_INSTR_VALID) begin
                    ld_ir     = 1'b1;
                    state_nxt = DECODE;
                end
            end
            DECODE: begin
                if (en) begin
                    ld_dec    = 1'b1;
                    state_nxt = EXECUTE;
                end
            end
            EXECUTE: begin
                if (en) begin
                    bus.O_ILLEGAL = d_illegal;
                    if (d_write) bus.O_REG_WRITE_ENABLE = 16'h0001 << d_ra;
                    state_nxt = d_load ? MEM_WAIT : FETCH;
                end
            end
            MEM_WAIT: begin
                bus.O_MEM_READ = en;
                if (en && bus.I_MEM_VALID) begin
                    bus.O_REG_WRITE_ENABLE = 16'h0001 << d_ra;
                    state_nxt              = FETCH;
                end
            end
            default: state_nxt = FETCH;
        endcase
    end

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            pc        <= PC_RESET;
            ir        <= 16'h0000;
            d_ra      <= 4'd0;
            d_rb      <= 4'd0;
            d_opc     <= 4'd0;
            d_imm     <= 16'h0000;
            d_rf_data <= 16'h0000;
            d_imm_sel <= 1'b0;
            d_rf_sel  <= 1'b0;
            d_mov     <= 1'b0;
            d_load    <= 1'b0;
            d_illegal <= 1'b0;
            d_write   <= 1'b0;
        end else begin
            if (ld_ir) begin
                ir <= bus.I_INSTR;
                pc <= pc + 16'd1;
            end
            if (ld_dec) begin
                d_ra      <= ir[11:8];
                d_rb      <= ir[3:0];
                d_opc     <= c_opc;
                d_imm     <= c_imm;
                d_rf_data <= c_rf_data;
                d_imm_sel <= c_imm_sel;
                d_rf_sel  <= c_rf_sel;
                d_mov     <= c_mov;
                d_load    <= c_load;
                d_illegal <= c_illegal;
                d_write   <= c_write;
            end
        end
    end

    assign bus.O_PC                  = pc;
    assign bus.O_MEM_ADDR            = bus.I_B;
    assign bus.O_REG_A_SELECT        = d_ra;
    assign bus.O_REG_B_SELECT        = d_rb;
    assign bus.O_OPCODE              = d_opc;
    assign bus.O_IMMEDIATE           = d_imm;
    assign bus.O_IMMEDIATE_SELECT    = d_imm_sel;
    // load data and MOV source bypass the ALU straight from their live inputs
    assign bus.O_REGFILE_DATA        = (state == MEM_WAIT)           ? bus.I_MEM_DATA :
                                       (state == EXECUTE && d_mov)   ? bus.I_B : d_rf_data;
    assign bus.O_REGFILE_DATA_SELECT = (state == MEM_WAIT) ? 1'b1 : d_rf_sel;
endmodule

// File: tb/tb_cr16_control.sv
// Scoreboarded bench for cr16_control: directed instructions push expected write/illegal
// events, a negedge monitor pops and compares them.
module tb_cr16_control;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cr16_control_if bus ();
    cr16_control_if bus2 ();

    cr16_control #(.PC_RESET(16'h0000)) dut      (.I_CLK(clk), .I_RESET(rst), .bus(bus.master));
    cr16_control #(.PC_RESET(16'hFFFF)) dut_wrap (.I_CLK(clk), .I_RESET(rst), .bus(bus2.master));

    typedef struct {
        logic [15:0] we;
        logic        ill;
        logic [15:0] pc;
        logic [3:0]  m;      // [0] regfile data, [1] opcode, [2] immediate, [3] selects
        logic [15:0] rf_data;
        logic        rf_sel;
        logic [3:0]  opc;
        logic [15:0] imm;
        logic        imm_sel;
        logic [3:0]  ra;
        logic [3:0]  rb;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [15:0] prev_we = 16'h0000;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] we, input logic ill, input logic [15:0] pc,
                                input logic [3:0] m, input logic [15:0] d, input logic ds,
                                input logic [3:0] opc, input logic [15:0] imm, input logic is_,
                                input logic [3:0] ra, input logic [3:0] rb);
        exp_t e;
        e.we = we; e.ill = ill; e.pc = pc; e.m = m; e.rf_data = d; e.rf_sel = ds;
        e.opc = opc; e.imm = imm; e.imm_sel = is_; e.ra = ra; e.rb = rb;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (bus.O_REG_WRITE_ENABLE != 16'h0000 || bus.O_ILLEGAL) begin
            chk("we_onehot", {31'd0, $onehot0(bus.O_REG_WRITE_ENABLE)}, 32'd1);
            chk("we_back_to_back", {31'd0, (prev_we != 16'h0000 && bus.O_REG_WRITE_ENABLE != 16'h0000)}, 32'd0);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_event: we=%h illegal=%b, want no event",
                         bus.O_REG_WRITE_ENABLE, bus.O_ILLEGAL);
            end else begin
                e = exp_q.pop_front();
                chk("ev_we", {16'd0, bus.O_REG_WRITE_ENABLE}, {16'd0, e.we});
                chk("ev_illegal", {31'd0, bus.O_ILLEGAL}, {31'd0, e.ill});
                chk("ev_pc", {16'd0, bus.O_PC}, {16'd0, e.pc});
                if (e.m[0]) begin
                    chk("ev_rf_data", {16'd0, bus.O_REGFILE_DATA}, {16'd0, e.rf_data});
                    chk("ev_rf_sel", {31'd0, bus.O_REGFILE_DATA_SELECT}, {31'd0, e.rf_sel});
                end
                if (e.m[1]) chk("ev_opcode", {28'd0, bus.O_OPCODE}, {28'd0, e.opc});
                if (e.m[2]) begin
                    chk("ev_imm", {16'd0, bus.O_IMMEDIATE}, {16'd0, e.imm});
                    chk("ev_imm_sel", {31'd0, bus.O_IMMEDIATE_SELECT}, {31'd0, e.imm_sel});
                end
                if (e.m[3]) begin
                    chk("ev_ra", {28'd0, bus.O_REG_A_SELECT}, {28'd0, e.ra});
                    chk("ev_rb", {28'd0, bus.O_REG_B_SELECT}, {28'd0, e.rb});
                end
            end
        end
        prev_we = bus.O_REG_WRITE_ENABLE;
    end

    task automatic wait_fetch(input string nm);
        int n = 0;
        while (!bus.O_FETCH_REQ && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            total++;
            bad++;
            $display("FAIL %s_fetch_timeout: got no fetch request, want one within 50 cycles", nm);
        end
    endtask

    // Issue one instruction with a zero-wait fetch; answer the load after mem_waits stall cycles.
    task automatic run_instr(input string nm, input logic [15:0] instr, input int mem_waits,
                             input int exp_cycles, input int exp_mr);
        int cyc = 1;
        int mw  = 0;
        wait_fetch(nm);
        bus.I_INSTR       = instr;
        bus.I_INSTR_VALID = 1'b1;
        @(posedge clk); #1;
        bus.I_INSTR_VALID = 1'b0;
        while (!bus.O_FETCH_REQ && cyc < 60) begin
            if (bus.O_MEM_READ) begin
                chk({nm, "_mem_addr"}, {16'd0, bus.O_MEM_ADDR}, {16'd0, bus.I_B});
                if (mw == mem_waits) bus.I_MEM_VALID = 1'b1;
                mw++;
            end
            @(posedge clk); #1;
            bus.I_MEM_VALID = 1'b0;
            cyc++;
        end
        chk({nm, "_cycles"}, cyc, exp_cycles);
        chk({nm, "_mem_read_cycles"}, mw, exp_mr);
    endtask

    initial begin
        bus.I_ENABLE  = 1'b1; bus.I_INSTR  = 16'h0; bus.I_INSTR_VALID  = 1'b0;
        bus.I_MEM_DATA = 16'h0; bus.I_MEM_VALID = 1'b0; bus.I_B = 16'h0;
        bus2.I_ENABLE = 1'b1; bus2.I_INSTR = 16'h0; bus2.I_INSTR_VALID = 1'b0;
        bus2.I_MEM_DATA = 16'h0; bus2.I_MEM_VALID = 1'b0; bus2.I_B = 16'h0;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_pc", {16'd0, bus.O_PC}, 32'h0000);
        chk("rst_fetch_req", {31'd0, bus.O_FETCH_REQ}, 32'd1);
        chk("rst_we", {16'd0, bus.O_REG_WRITE_ENABLE}, 32'd0);
        chk("rst_mem_read", {31'd0, bus.O_MEM_READ}, 32'd0);
        chk("rst_rf_data", {16'd0, bus.O_REGFILE_DATA}, 32'd0);
        chk("rst_wrap_pc", {16'd0, bus2.O_PC}, 32'hFFFF);

        // MOVI R1,#7 ; ADDI R1,#-1 ; XOR R3,R2 ; LUI R6,#AB
        exp_q.push_back(mk(16'h0002, 0, 16'h0001, 4'b1001, 16'h0007, 1, 0, 0, 0, 4'd1, 4'd7));
        run_instr("movi", 16'hD107, 0, 3, 0);
        exp_q.push_back(mk(16'h0002, 0, 16'h0002, 4'b0111, 16'h0000, 0, 4'd0, 16'hFFFF, 1, 0, 0));
        run_instr("addi", 16'h51FF, 0, 3, 0);
        chk("pc_after_addi", {16'd0, bus.O_PC}, 32'h0002);
        exp_q.push_back(mk(16'h0008, 0, 16'h0003, 4'b1111, 16'h0000, 0, 4'd7, 16'h0000, 0, 4'd3, 4'd2));
        run_instr("xor", 16'h0332, 0, 3, 0);
        exp_q.push_back(mk(16'h0040, 0, 16'h0004, 4'b1001, 16'hAB00, 1, 0, 0, 0, 4'd6, 4'd11));
        run_instr("lui", 16'hF6AB, 0, 3, 0);

        // LOAD R5,[R4] with three memory wait cycles
        bus.I_B        = 16'h1234;
        bus.I_MEM_DATA = 16'hBEEF;
        exp_q.push_back(mk(16'h0020, 0, 16'h0005, 4'b1001, 16'hBEEF, 1, 0, 0, 0, 4'd5, 4'd4));
        run_instr("load", 16'h4504, 3, 7, 4);

        exp_q.push_back(mk(16'h0000, 1, 16'h0006, 4'b0000, 0, 0, 0, 0, 0, 0, 0));
        run_instr("illegal", 16'h0F80, 0, 3, 0);
        chk("pc_after_illegal", {16'd0, bus.O_PC}, 32'h0006);

        // LOAD stalled 5 cycles in EXECUTE, then reset while a load response is arriving
        wait_fetch("en_load");
        bus.I_INSTR = 16'h4504; bus.I_INSTR_VALID = 1'b1;
        @(posedge clk); #1 bus.I_INSTR_VALID = 1'b0;
        @(posedge clk); #1;
        bus.I_ENABLE = 1'b0; bus.I_INSTR_VALID = 1'b1; bus.I_MEM_VALID = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("dis_fetch_req", {31'd0, bus.O_FETCH_REQ}, 32'd0);
            chk("dis_mem_read", {31'd0, bus.O_MEM_READ}, 32'd0);
            chk("dis_we", {16'd0, bus.O_REG_WRITE_ENABLE}, 32'd0);
            chk("dis_pc", {16'd0, bus.O_PC}, 32'h0007);
            @(posedge clk); #1;
        end
        bus.I_ENABLE = 1'b1; bus.I_INSTR_VALID = 1'b0; bus.I_MEM_VALID = 1'b0;
        #1 chk("en_still_exec", {31'd0, bus.O_MEM_READ}, 32'd0);
        @(posedge clk); #1;
        chk("en_mem_wait", {31'd0, bus.O_MEM_READ}, 32'd1);
        rst = 1'b1; bus.I_MEM_VALID = 1'b1;
        #1 chk("rst_mw_we", {16'd0, bus.O_REG_WRITE_ENABLE}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; bus.I_MEM_VALID = 1'b0;
        #1;
        chk("post_rst_pc", {16'd0, bus.O_PC}, 32'h0000);
        chk("post_rst_fetch", {31'd0, bus.O_FETCH_REQ}, 32'd1);

        // SUBI/ANDI share imm8 0x80 to separate sign- from zero-extension; then MOV
        exp_q.push_back(mk(16'h0400, 0, 16'h0001, 4'b0111, 16'h0000, 0, 4'd3, 16'hFF80, 1, 0, 0));
        run_instr("subi", 16'h9A80, 0, 3, 0);
        exp_q.push_back(mk(16'h0400, 0, 16'h0002, 4'b0111, 16'h0000, 0, 4'd5, 16'h0080, 1, 0, 0));
        run_instr("andi", 16'h1A80, 0, 3, 0);
        bus.I_B = 16'h5A5A;
        exp_q.push_back(mk(16'h0080, 0, 16'h0003, 4'b1001, 16'h5A5A, 1, 0, 0, 0, 4'd7, 4'd4));
        run_instr("mov", 16'h07D4, 0, 3, 0);

        // PC wrap: second instance starts at FFFF
        chk("wrap_pc_before", {16'd0, bus2.O_PC}, 32'hFFFF);
        bus2.I_INSTR = 16'h0F80; bus2.I_INSTR_VALID = 1'b1;
        @(posedge clk); #1 bus2.I_INSTR_VALID = 1'b0;
        chk("wrap_pc_after", {16'd0, bus2.O_PC}, 32'h0000);
        @(posedge clk); #1;
        chk("wrap_illegal", {31'd0, bus2.O_ILLEGAL}, 32'd1);
        chk("wrap_we", {16'd0, bus2.O_REG_WRITE_ENABLE}, 32'd0);
        @(posedge clk); #1;
        chk("wrap_illegal_end", {31'd0, bus2.O_ILLEGAL}, 32'd0);
        chk("wrap_fetch", {31'd0, bus2.O_FETCH_REQ}, 32'd1);
        chk("wrap_pc_fetch", {16'd0, bus2.O_PC}, 32'h0000);

        repeat (3) @(posedge clk);
        #1 chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation still running, want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
